// File: rtl/led_pattern_engine_pkg.sv
`default_nettype none
//==============================================================================
// Package : led_pkg
// Brief   : Shared mode/FSM/speed encodings for the LED pattern engine.
// Rev     : 1.0 - initial release
//==============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        CHASE  = 2'd0,
        BOUNCE = 2'd1,
        FILL   = 2'd2
    } e_mode;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLASH = 1'b1
    } e_fsm;

    typedef enum logic [1:0] {
        FAST   = 2'd0,
        NORMAL = 2'd1,
        SLOW   = 2'd2
    } e_speed;

    function automatic e_speed next_speed(input e_speed s);
        case (s)
            NORMAL:  return FAST;
            FAST:    return SLOW;
            default: return NORMAL;
        endcase
    endfunction

    function automatic e_mode next_mode(input e_mode m);
        case (m)
            CHASE:   return BOUNCE;
            BOUNCE:  return FILL;
            default: return CHASE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_engine_btn_debounce.sv
`default_nettype none
//==============================================================================
// Module : btn_debounce
// Brief  : 2-FF synchroniser, stability-count debouncer and press-edge pulse.
// Rev    : 1.0 - initial release
//==============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Any return to the filtered level restarts the stability count.
            if (r_sync2 != r_level) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2;
                    r_press <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/led_pattern_engine.sv
`default_nettype none
//==============================================================================
// Module : led_pattern_engine
// Brief  : Button-controlled CHASE/BOUNCE/FILL pattern driver for active-low LEDs.
// Rev    : 1.0 - initial release
//==============================================================================
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int NUM_LEDS        = 4,
    parameter int BASE_STEP       = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_dir,
    input  logic                btn_speed,
    input  logic                btn_mode,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode_o,
    output logic [1:0]          speed_o,
    output logic                dir_o
);

    localparam int c_CNT_W = $clog2(2 * BASE_STEP);
    localparam int c_POS_W = $clog2(NUM_LEDS);
    localparam int c_LVL_W = $clog2(NUM_LEDS + 1);

    localparam logic [c_CNT_W-1:0] c_LAST_FAST   = c_CNT_W'(BASE_STEP / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_NORMAL = c_CNT_W'(BASE_STEP - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_SLOW   = c_CNT_W'(2 * BASE_STEP - 1);
    localparam logic [c_POS_W-1:0] c_POS_LAST    = c_POS_W'(NUM_LEDS - 1);
    localparam logic [c_LVL_W-1:0] c_LVL_FULL    = c_LVL_W'(NUM_LEDS);

    function automatic logic [c_POS_W-1:0] start_pos(input logic d);
        return d ? c_POS_LAST : '0;
    endfunction

    logic       w_press_dir;
    logic       w_press_speed;
    logic       w_press_mode;
    logic [2:0] w_btn_level_unused;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_dir),
        .level (w_btn_level_unused[0]),
        .press (w_press_dir)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_speed),
        .level (w_btn_level_unused[1]),
        .press (w_press_speed)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_mode),
        .level (w_btn_level_unused[2]),
        .press (w_press_mode)
    );

    e_mode                r_mode;
    e_speed               r_speed;
    e_fsm                 r_fsm;
    logic                 r_dir;
    logic [c_POS_W-1:0]   r_pos;
    logic [c_LVL_W-1:0]   r_level;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [NUM_LEDS-1:0]  r_led;

    e_mode                w_mode_nxt;
    e_speed               w_speed_nxt;
    e_fsm                 w_fsm_nxt;
    logic                 w_dir_nxt;
    logic [c_POS_W-1:0]   w_pos_nxt;
    logic [c_LVL_W-1:0]   w_level_nxt;
    logic [NUM_LEDS-1:0]  w_led_nxt;
    logic [c_CNT_W-1:0]   w_cnt_last;
    logic                 w_tick;
    logic                 w_clr;

    always_comb begin
        case (r_speed)
            FAST:    w_cnt_last = c_LAST_FAST;
            SLOW:    w_cnt_last = c_LAST_SLOW;
            default: w_cnt_last = c_LAST_NORMAL;
        endcase
    end

    assign w_tick = (r_cnt == w_cnt_last);

    always_comb begin
        w_mode_nxt  = r_mode;
        w_speed_nxt = r_speed;
        w_fsm_nxt   = r_fsm;
        w_dir_nxt   = r_dir;
        w_pos_nxt   = r_pos;
        w_level_nxt = r_level;
        w_clr       = 1'b0;

        if (w_tick) begin
            if (r_fsm == FLASH) begin
                w_fsm_nxt   = RUN;
                w_pos_nxt   = start_pos(r_dir);
                w_level_nxt = '0;
            end else begin
                case (r_mode)
                    CHASE: begin
                        if (r_dir)
                            w_pos_nxt = (r_pos == '0) ? c_POS_LAST : r_pos - 1'b1;
                        else
                            w_pos_nxt = (r_pos == c_POS_LAST) ? '0 : r_pos + 1'b1;
                    end
                    BOUNCE: begin
                        // Leaving an end reverses instead of wrapping, so the end LED lasts one step.
                        if (!r_dir) begin
                            if (r_pos == c_POS_LAST) begin
                                w_dir_nxt = 1'b1;
                                w_pos_nxt = c_POS_LAST - 1'b1;
                            end else begin
                                w_pos_nxt = r_pos + 1'b1;
                            end
                        end else begin
                            if (r_pos == '0) begin
                                w_dir_nxt = 1'b0;
                                w_pos_nxt = c_POS_W'(1);
                            end else begin
                                w_pos_nxt = r_pos - 1'b1;
                            end
                        end
                    end
                    FILL: begin
                        w_level_nxt = (r_level == c_LVL_FULL) ? '0 : r_level + 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        if (w_press_mode) begin
            w_mode_nxt  = next_mode(r_mode);
            w_pos_nxt   = start_pos(w_dir_nxt);
            w_level_nxt = '0;
            w_clr       = 1'b1;
        end

        if (w_press_speed) begin
            w_speed_nxt = next_speed(r_speed);
            w_clr       = 1'b1;
        end

        // Direction is applied last so a simultaneous press always ends in FLASH.
        if (w_press_dir) begin
            w_dir_nxt = ~w_dir_nxt;
            w_fsm_nxt = FLASH;
            w_clr     = 1'b1;
        end
    end

    always_comb begin
        w_led_nxt = '1;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_fsm_nxt == FLASH)
                w_led_nxt[i] = 1'b0;
            else if (w_mode_nxt == FILL)
                w_led_nxt[i] = w_dir_nxt ? !(c_LVL_W'(NUM_LEDS - 1 - i) < w_level_nxt)
                                         : !(c_LVL_W'(i) < w_level_nxt);
            else
                w_led_nxt[i] = !(c_POS_W'(i) == w_pos_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode  <= CHASE;
            r_speed <= NORMAL;
            r_fsm   <= RUN;
            r_dir   <= 1'b0;
            r_pos   <= '0;
            r_level <= '0;
            r_cnt   <= '0;
            r_led   <= '1;
        end else begin
            r_mode  <= w_mode_nxt;
            r_speed <= w_speed_nxt;
            r_fsm   <= w_fsm_nxt;
            r_dir   <= w_dir_nxt;
            r_pos   <= w_pos_nxt;
            r_level <= w_level_nxt;
            r_cnt   <= (w_clr || w_tick) ? '0 : r_cnt + 1'b1;
            r_led   <= w_led_nxt;
        end
    end

    assign led     = r_led;
    assign mode_o  = r_mode;
    assign speed_o = r_speed;
    assign dir_o   = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`default_nettype none
//==============================================================================
// Module : tb_led_pattern_engine
// Brief  : Directed self-checking bench for led_pattern_engine (4 LEDs, fast timing).
// Rev    : 1.0 - initial release
//==============================================================================
module tb_led_pattern_engine;

    logic       clk;
    logic       reset;
    logic       btn_dir;
    logic       btn_speed;
    logic       btn_mode;
    logic [3:0] led;
    logic [1:0] mode_o;
    logic [1:0] speed_o;
    logic       dir_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [3:0] c_CHASE_LED  [3] = '{4'b1011, 4'b0111, 4'b1110};
    localparam logic [3:0] c_BOUNCE_LED [6] = '{4'b1011, 4'b1101, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic       c_BOUNCE_DIR [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [3:0] c_FILL_LED   [5] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b1111};

    led_pattern_engine #(
        .NUM_LEDS        (4),
        .BASE_STEP       (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_dir   (btn_dir),
        .btn_speed (btn_speed),
        .btn_mode  (btn_mode),
        .led       (led),
        .mode_o    (mode_o),
        .speed_o   (speed_o),
        .dir_o     (dir_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] e_led, input logic [1:0] e_mode,
                             input logic [1:0] e_speed, input logic e_dir);
        chk({tag, ".led"},   32'(led),     32'(e_led));
        chk({tag, ".mode"},  32'(mode_o),  32'(e_mode));
        chk({tag, ".speed"}, 32'(speed_o), 32'(e_speed));
        chk({tag, ".dir"},   32'(dir_o),   32'(e_dir));
    endtask

    initial begin
        reset     = 1'b0;
        btn_dir   = 1'b1;
        btn_speed = 1'b1;
        btn_mode  = 1'b1;
        cyc(3);
        chk_state("reset", 4'b1111, 2'd0, 2'd1, 1'b0);

        // CHASE ascending, one step per 8 cycles
        reset = 1'b1;
        cyc(1);
        chk("chase0", 32'(led), 32'h0000_000e);
        cyc(6);
        chk("chase0_hold", 32'(led), 32'h0000_000e);
        cyc(1);
        chk("chase1", 32'(led), 32'h0000_000d);
        for (int k = 0; k < 3; k++) begin
            cyc(7);
            chk("chase_hold", 32'(led), 32'(k == 0 ? 4'b1101 : c_CHASE_LED[k-1]));
            cyc(1);
            chk("chase_step", 32'(led), 32'(c_CHASE_LED[k]));
        end

        // Held direction button: single pulse, 8-cycle flash, restart from the top
        btn_dir = 1'b0;
        cyc(6);
        chk_state("dir_pre", 4'b1110, 2'd0, 2'd1, 1'b0);
        cyc(1);
        chk_state("dir_flash", 4'b0000, 2'd0, 2'd1, 1'b1);
        cyc(7);
        chk("flash_hold", 32'(led), 32'h0000_0000);
        cyc(1);
        chk("flash_end", 32'(led), 32'h0000_0007);
        cyc(5);
        btn_dir = 1'b1;
        cyc(3);
        chk("desc1", 32'(led), 32'h0000_000b);
        cyc(8);
        chk_state("desc2_single_pulse", 4'b1101, 2'd0, 2'd1, 1'b1);

        // Speed NORMAL -> FAST
        btn_speed = 1'b0;
        cyc(6);
        chk("speed_pre", 32'(speed_o), 32'd1);
        btn_speed = 1'b1;
        cyc(1);
        chk_state("speed_fast", 4'b1101, 2'd0, 2'd0, 1'b1);
        cyc(3);
        chk("fast_hold", 32'(led), 32'h0000_000d);
        cyc(1);
        chk("fast_step1", 32'(led), 32'h0000_000e);
        cyc(4);
        chk("fast_wrap", 32'(led), 32'h0000_0007);

        // Speed FAST -> SLOW
        btn_speed = 1'b0;
        cyc(4);
        chk("fast_step3", 32'(led), 32'h0000_000b);
        cyc(2);
        btn_speed = 1'b1;
        cyc(1);
        chk("speed_slow", 32'(speed_o), 32'd2);
        cyc(15);
        chk("slow_hold", 32'(led), 32'h0000_000b);
        cyc(1);
        chk("slow_step", 32'(led), 32'h0000_000d);

        // 3-cycle glitch is filtered out
        btn_speed = 1'b0;
        cyc(3);
        btn_speed = 1'b1;
        cyc(9);

        // Simultaneous mode + speed: BOUNCE at NORMAL speed, start at top for dir 1
        btn_mode  = 1'b0;
        btn_speed = 1'b0;
        cyc(4);
        chk_state("glitch_ignored", 4'b1110, 2'd0, 2'd2, 1'b1);
        cyc(2);
        btn_mode  = 1'b1;
        btn_speed = 1'b1;
        cyc(1);
        chk_state("bounce_start", 4'b0111, 2'd1, 2'd1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc(8);
            chk("bounce_led", 32'(led),   32'(c_BOUNCE_LED[k]));
            chk("bounce_dir", 32'(dir_o), 32'(c_BOUNCE_DIR[k]));
        end

        // FILL ascending with dir 0
        btn_mode = 1'b0;
        cyc(6);
        btn_mode = 1'b1;
        cyc(1);
        chk_state("fill_start", 4'b1111, 2'd2, 2'd1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(8);
            chk("fill_step", 32'(led), 32'(c_FILL_LED[k]));
        end
        cyc(8);
        chk("fill_again", 32'(led), 32'h0000_000e);

        // One-cycle reset mid-FILL, then mode and dir pressed together
        reset = 1'b0;
        cyc(1);
        chk_state("reset_mid", 4'b1111, 2'd0, 2'd1, 1'b0);
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_dir  = 1'b0;
        cyc(6);
        chk_state("post_reset_run", 4'b1110, 2'd0, 2'd1, 1'b0);
        btn_mode = 1'b1;
        btn_dir  = 1'b1;
        cyc(1);
        chk_state("combo_flash", 4'b0000, 2'd1, 2'd1, 1'b1);
        cyc(7);
        chk("combo_flash_hold", 32'(led), 32'h0000_0000);
        cyc(1);
        chk("combo_bounce_top", 32'(led), 32'h0000_0007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised successor to the 4-LED running-light block: drives NUM_LEDS active-low LEDs with selectable pattern mode, direction and speed.
- Three raw push-buttons are synchronised, debounced and edge-detected inside the block; every state change is synchronous to clk, with no button-clocked logic.
- Sits directly between board buttons and board LEDs; status outputs feed a future UART/7-segment debug block.

Parameters:
- NUM_LEDS, 4, number of LEDs (2..16).
- BASE_STEP, 50_000_000, clk cycles per pattern step at speed level 1.
- DEBOUNCE_CYCLES, 500_000, consecutive stable synchronised cycles required to accept a button level.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- btn_dir  in  1  raw button, active-low; press = toggle direction (with flash).
- btn_speed  in  1  raw button, active-low; press = next speed level.
- btn_mode  in  1  raw button, active-low; press = next pattern mode.
- led  out  NUM_LEDS  LED drive, active-low (0 = lit).
- mode_o  out  2  current mode (0 CHASE, 1 BOUNCE, 2 FILL).
- speed_o  out  2  current speed level (0 fast, 1 normal, 2 slow).
- dir_o  out  1  0 = ascending index, 1 = descending.

Behaviour:
- Reset (reset==0 at a clk edge):
  - led = all 1s; mode CHASE; speed 1; dir 0; pos 0; fill level 0.
  - step counter 0; FSM in RUN; debounce filters = 1 (released).
- Button path, per button:
  - 2-FF synchroniser, then debounce counter.
  - Filtered level changes only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Press pulse is one cycle, on filtered 1->0.
  - Latency from raw fall to pulse: 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
  - Holding a button produces exactly one pulse.
- Step period by speed level:
  - 0 -> BASE_STEP/2; 1 -> BASE_STEP; 2 -> BASE_STEP*2.
  - Counter width is sized for BASE_STEP*2; no overflow.
  - Tick asserts when counter == period-1; counter then returns to 0.
- Speed press cycles 1->0->2->1. Counter clears in the same cycle, so the next tick comes a full new period later.
- FSM states RUN and FLASH:
  - RUN: on each tick, update pattern per mode.
  - btn_dir pulse in RUN: toggle dir, drive all LEDs lit (all 0s), clear counter, enter FLASH.
  - FLASH: on the next tick, return to RUN and load the start position.
    - Start position is pos 0 for dir 0, pos NUM_LEDS-1 for dir 1.
    - FILL restarts at level 0.
  - btn_dir pulse during FLASH: toggles dir again and restarts the flash period.
- CHASE:
  - Exactly one LED lit, at index pos.
  - Tick: pos ±1 per dir, with wrap: NUM_LEDS-1 -> 0 ascending, 0 -> NUM_LEDS-1 descending.
- BOUNCE:
  - One LED lit at pos; motion as CHASE.
  - At an end, dir flips instead of wrapping; the end LED is shown for one step only, never two.
  - dir_o tracks the flip.
- FILL:
  - Level 0..NUM_LEDS LEDs lit.
  - dir 0 fills from index 0 upward; dir 1 fills from index NUM_LEDS-1 downward.
  - Tick: level+1; after NUM_LEDS the next tick gives level 0 (all off).
- Mode press cycles CHASE->BOUNCE->FILL->CHASE.
  - Clears counter and loads the start position for the current dir; level 0.
  - LEDs update in the same cycle as the pulse.
- Simultaneous pulses in one cycle:
  - Mode and speed are both applied.
  - If dir is also present, dir/FLASH is applied last, so FLASH wins the LED output.
- All outputs are registered. LED changes appear the cycle after the tick or pulse.

Decomposition:
- Package led_pkg holds:
  - enums e_mode {CHASE, BOUNCE, FILL}, e_fsm {RUN, FLASH}, e_speed {FAST, NORMAL, SLOW};
  - function next_speed().
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, btn_n, level, press). It is instantiated three times.

Test Plan (NUM_LEDS=4, BASE_STEP=8, DEBOUNCE_CYCLES=4):
- Reset released, no buttons -> led 1110, 1101, 1011, 0111, 1110, one change every 8 cycles.
- btn_dir held low 20 cycles -> one pulse 6 cycles after the fall; led 0000 for 8 cycles, then 0111, then 1011; dir_o=1.
- btn_speed pressed once, then twice -> speed_o 0 with 4-cycle steps; then speed_o 2 with 16-cycle steps; a 3-cycle glitch gives no change.
- Mode to BOUNCE -> led sequence 1110, 1101, 1011, 0111, 1011, 1101, 1110; dir_o toggles at each end.
- Mode to FILL, dir 0 -> led 1111, 1110, 1100, 1000, 0000, 1111.
- reset low for 1 cycle mid-FILL, then btn_mode and btn_dir pulses in the same cycle -> outputs return to reset values; after the pulses mode_o=1, led 0000 (FLASH), dir_o=1.
